piece_queue: RTL

Consumer side of the tetromino generator interface. Requests pieces from the generator with a one-cycle `new_block` pulse and captures `gen_idx` in that same cycle. Keeps a current piece, a preview queue of `DEPTH` upcoming pieces and a single-slot hold. Sits between the generator and the game-control FSM, which spawns pieces and issues hold requests.

---
 rtl/tetris_pkg.sv | 23 ++
 rtl/piece_queue_if.sv | 35 +++
 rtl/piece_queue_preview_shift.sv | 39 +++
 rtl/piece_queue.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types for the tetromino piece path: piece index width, piece count,
// the queue FSM state encoding and the out-of-range index clamp.
// Latency: n/a (declarations only). Backpressure: n/a.
package tetris_pkg;

  localparam int PIECE_W    = 3;
  localparam int NUM_PIECES = 7;

  typedef logic [PIECE_W-1:0] piece_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } queue_state_t;

  // The generator can present 7, which names no piece; it maps onto piece 0
  // so that the queue only ever holds legal indices.
  function automatic piece_t clamp_piece(input piece_t raw);
    return (raw >= piece_t'(NUM_PIECES)) ? piece_t'(0) : raw;
  endfunction

endpackage

// File: rtl/piece_queue_if.sv
// Bundle between the piece queue, the generator and the game-control FSM.
// Latency: n/a (wires only). Backpressure: none; new_block is the only request.
// Ports: spawn_req/hold_req/gen_idx into the queue; new_block, cur/next/hold
// piece state and ready out of it. The slave modport is the queue itself.
interface piece_queue_if
  import tetris_pkg::*;
#(
  parameter int DEPTH = 3
) ();

  logic                       spawn_req;
  logic                       hold_req;
  piece_t                     gen_idx;
  logic                       new_block;
  piece_t                     cur_idx;
  logic                       cur_valid;
  logic [PIECE_W*DEPTH-1:0]   next_idx;
  piece_t                     hold_idx;
  logic                       hold_valid;
  logic                       hold_used;
  logic                       ready;

  modport master (
    output spawn_req, hold_req, gen_idx,
    input  new_block, cur_idx, cur_valid, next_idx,
    input  hold_idx, hold_valid, hold_used, ready
  );

  modport slave (
    input  spawn_req, hold_req, gen_idx,
    output new_block, cur_idx, cur_valid, next_idx,
    output hold_idx, hold_valid, hold_used, ready
  );

endinterface

// File: rtl/piece_queue_preview_shift.sv
// DEPTH-slot preview register: indexed write for start-up fill, shift-down
// with tail insert for every advance. Latency: 1 cycle write-to-read.
// Backpressure: none; shift has priority over the indexed write.
// Ports: Clk, Reset (sync, active-high); wr_en_i/wr_idx_i/wr_dat_i;
// shift_en_i/tail_dat_i; slots_o packed with slot 0 in the low bits.
module preview_shift
  import tetris_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          wr_en_i,
  input  logic [CNT_W-1:0]              wr_idx_i,
  input  piece_t                        wr_dat_i,
  input  logic                          shift_en_i,
  input  piece_t                        tail_dat_i,
  output logic [DEPTH-1:0][PIECE_W-1:0] slots_o
);

  logic [DEPTH-1:0][PIECE_W-1:0] slots_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      slots_q <= '0;
    end else if (shift_en_i) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        slots_q[i] <= slots_q[i+1];
      end
      slots_q[DEPTH-1] <= tail_dat_i;
    end else if (wr_en_i) begin
      slots_q[wr_idx_i] <= wr_dat_i;
    end
  end

  assign slots_o = slots_q;

endmodule

// File: rtl/piece_queue.sv
// Consumer of the tetromino generator: current piece, DEPTH-slot preview and
// one hold slot. Latency: request in cycle N visible in cycle N+1; gen_idx is
// taken in the same cycle new_block is high. Backpressure: none; requests
// outside RUN and repeated holds within one spawn are dropped, not queued.
// Ports: Clk, Reset (sync, active-high); bus (slave modport of piece_queue_if).
module piece_queue
  import tetris_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  piece_queue_if.slave bus
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  queue_state_t state_q, state_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  piece_t cur_q, cur_d;
  logic   cur_vld_q, cur_vld_d;
  piece_t hold_q, hold_d;
  logic   hold_vld_q, hold_vld_d;
  logic   hold_used_q, hold_used_d;

  logic   wr_en;
  logic   shift_en;
  logic   new_block;
  piece_t gen_piece;
  logic [DEPTH-1:0][PIECE_W-1:0] slots;

  assign gen_piece = clamp_piece(bus.gen_idx);

  preview_shift #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_preview (
    .Clk        (Clk),
    .Reset      (Reset),
    .wr_en_i    (wr_en),
    .wr_idx_i   (fill_cnt_q),
    .wr_dat_i   (gen_piece),
    .shift_en_i (shift_en),
    .tail_dat_i (gen_piece),
    .slots_o    (slots)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= FILL;
      fill_cnt_q  <= '0;
      cur_q       <= '0;
      cur_vld_q   <= 1'b0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      hold_used_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      cur_q       <= cur_d;
      cur_vld_q   <= cur_vld_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      hold_used_q <= hold_used_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    cur_d       = cur_q;
    cur_vld_d   = cur_vld_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    hold_used_d = hold_used_q;
    wr_en       = 1'b0;
    shift_en    = 1'b0;
    new_block   = 1'b0;

    unique case (state_q)
      FILL: begin
        new_block = 1'b1;
        wr_en     = 1'b1;
        if (fill_cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = PRIME;
        end else begin
          fill_cnt_d = fill_cnt_q + CNT_W'(1);
        end
      end

      PRIME: begin
        new_block = 1'b1;
        shift_en  = 1'b1;
        cur_d     = piece_t'(slots[0]);
        cur_vld_d = 1'b1;
        state_d   = RUN;
      end

      RUN: begin
        // Spawn outranks hold when both arrive together.
        if (bus.spawn_req) begin
          new_block   = 1'b1;
          shift_en    = 1'b1;
          cur_d       = piece_t'(slots[0]);
          hold_used_d = 1'b0;
        end else if (bus.hold_req && !hold_used_q) begin
          hold_used_d = 1'b1;
          if (!hold_vld_q) begin
            // First hold parks the current piece and pulls the next one.
            hold_d     = cur_q;
            hold_vld_d = 1'b1;
            new_block  = 1'b1;
            shift_en   = 1'b1;
            cur_d      = piece_t'(slots[0]);
          end else begin
            // Swap leaves the preview untouched, so nothing is consumed.
            hold_d = cur_q;
            cur_d  = hold_q;
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase

    // Nothing is consumed from the generator while held in reset.
    if (Reset) begin
      new_block = 1'b0;
    end
  end

  assign bus.new_block  = new_block;
  assign bus.cur_idx    = cur_q;
  assign bus.cur_valid  = cur_vld_q;
  assign bus.next_idx   = slots;
  assign bus.hold_idx   = hold_q;
  assign bus.hold_valid = hold_vld_q;
  assign bus.hold_used  = hold_used_q;
  assign bus.ready      = (state_q == RUN);

endmodule
